// File: rtl/acc_alu.sv
// acc_alu: handshaked accumulator ALU (add/sub/and/or/xor/shl/mul/clear).
// Optional shift-add multiplier is built only when ACC_ALU_MUL_EN is defined;
// without it, op 110 completes through EXEC flagged as illegal (err=1).
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// EXEC  | single-cycle compute of the latched operands
// MUL   | shift-add multiply, one multiplier bit per cycle (ACC_ALU_MUL_EN)
// DONE  | result presented, held until out_ready
module acc_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
`ifdef ACC_ALU_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa_sel;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] shl_wide;
  logic [WIDTH-1:0]   res_y;
  logic               res_c;
  logic               res_e;

`ifdef ACC_ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod_next;
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign opa_sel   = use_acc ? acc : a;

  // Single-cycle result of the latched operation; the extra top bit of the
  // widened add/sub/shift gives carry, borrow and last-bit-shifted-out.
  always_comb begin
    sum      = {1'b0, opa} + {1'b0, opb};
    diff     = {1'b0, opa} - {1'b0, opb};
    shl_wide = {{WIDTH{1'b0}}, opa} << opb[SW-1:0];
    res_y    = '0;
    res_c    = 1'b0;
    res_e    = 1'b0;
    case (op_q)
      3'b000: begin res_y = sum[WIDTH-1:0];      res_c = sum[WIDTH];      end
      3'b001: begin res_y = diff[WIDTH-1:0];     res_c = diff[WIDTH];     end
      3'b010: res_y = opa & opb;
      3'b011: res_y = opa | opb;
      3'b100: res_y = opa ^ opb;
      3'b101: begin res_y = shl_wide[WIDTH-1:0]; res_c = shl_wide[WIDTH]; end
      // Multiply only reaches EXEC when the multiplier is not built.
      3'b110: res_e = 1'b1;
      default: res_y = '0;
    endcase
  end

`ifdef ACC_ALU_MUL_EN
  // Partial product after adding the current multiplicand when the multiplier LSB is set.
  always_comb begin
    prod_next = mplier[0] ? (prod + mcand) : prod;
  end
`endif

  // Control FSM, operand latch, result registers and accumulator update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      opa   <= '0;
      opb   <= '0;
      op_q  <= '0;
      acc   <= '0;
      y     <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      err   <= 1'b0;
`ifdef ACC_ALU_MUL_EN
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            opa  <= opa_sel;
            opb  <= b;
            op_q <= op;
`ifdef ACC_ALU_MUL_EN
            if (op == 3'b110) begin
              prod   <= '0;
              mcand  <= {{WIDTH{1'b0}}, opa_sel};
              mplier <= b;
              cnt    <= SW'(WIDTH - 1);
              state  <= S_MUL;
            end else begin
              state <= S_EXEC;
            end
`else
            state <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          y     <= res_y;
          carry <= res_c;
          zero  <= (res_y == '0);
          err   <= res_e;
          state <= S_DONE;
        end
`ifdef ACC_ALU_MUL_EN
        S_MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) begin
            y     <= prod_next[WIDTH-1:0];
            carry <= |prod_next[2*WIDTH-1:WIDTH];
            zero  <= (prod_next[WIDTH-1:0] == '0);
            err   <= 1'b0;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            // An illegal op leaves the accumulator untouched; clear already has y=0.
            if (!err) acc <= y;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_alu.sv
// Directed self-checking bench for acc_alu (WIDTH=8). Multiplier expectations
// follow whether ACC_ALU_MUL_EN is defined for the build.
module tb_acc_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       use_acc = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] y;
  logic       carry;
  logic       zero;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       u;
    logic [7:0] y;
    logic       c;
    logic       z;
    logic       e;
    int         lat;
  } vec_t;

`ifdef ACC_ALU_MUL_EN
  localparam int MUL_LAT = 9;
`else
  localparam int MUL_LAT = 2;
`endif

  acc_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .use_acc(use_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .carry(carry), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  // Issue one request, measure edges from accept (accept edge = 1) to out_valid,
  // capture the result, then complete the output handshake.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top,
                        input logic tu, output int lat, output logic [7:0] ry,
                        output logic rc, output logic rz, output logic re);
    @(negedge clk);
    a = ta; b = tb_; op = top; use_acc = tu; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    ry = y; rc = carry; rz = zero; re = err;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [7:0] ry; logic rc, rz, re;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 8'h12; b = 8'h34;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, y, carry, zero, err} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got ov=%b ir=%b y=%h c=%b z=%b e=%b want ov=0 ir=1 y=00 c=0 z=0 e=0",
               out_valid, in_ready, y, carry, zero, err);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    run_op(8'h55, 8'h00, 3'b000, 1'b1, lat, ry, rc, rz, re);
    total++;
    if ({ry, rc, rz, re} !== {8'h00, 1'b0, 1'b1, 1'b0} || lat !== 2) begin
      bad++;
      $display("FAIL reset_acc_zero got y=%h c=%b z=%b e=%b lat=%0d want y=00 c=0 z=1 e=0 lat=2",
               ry, rc, rz, re, lat);
    end
  endtask

  task automatic test_arith();
    vec_t t[3];
    int lat; logic [7:0] ry; logic rc, rz, re;
    t[0] = '{a:8'd200, b:8'd100, op:3'b000, u:1'b0, y:8'd44,  c:1'b1, z:1'b0, e:1'b0, lat:2};
    t[1] = '{a:8'd3,   b:8'd5,   op:3'b001, u:1'b0, y:8'd254, c:1'b1, z:1'b0, e:1'b0, lat:2};
    t[2] = '{a:8'd5,   b:8'd3,   op:3'b001, u:1'b0, y:8'd2,   c:1'b0, z:1'b0, e:1'b0, lat:2};
    for (int i = 0; i < 3; i++) begin
      run_op(t[i].a, t[i].b, t[i].op, t[i].u, lat, ry, rc, rz, re);
      total++;
      if ({ry, rc, rz, re} !== {t[i].y, t[i].c, t[i].z, t[i].e} || lat !== t[i].lat) begin
        bad++;
        $display("FAIL arith[%0d] got y=%h c=%b z=%b e=%b lat=%0d want y=%h c=%b z=%b e=%b lat=%0d",
                 i, ry, rc, rz, re, lat, t[i].y, t[i].c, t[i].z, t[i].e, t[i].lat);
      end
    end
  endtask

  task automatic test_logic_shift();
    vec_t t[6];
    int lat; logic [7:0] ry; logic rc, rz, re;
    t[0] = '{a:8'hF0, b:8'h3C, op:3'b010, u:1'b0, y:8'h30, c:1'b0, z:1'b0, e:1'b0, lat:2};
    t[1] = '{a:8'hF0, b:8'h3C, op:3'b011, u:1'b0, y:8'hFC, c:1'b0, z:1'b0, e:1'b0, lat:2};
    t[2] = '{a:8'hF0, b:8'h3C, op:3'b100, u:1'b0, y:8'hCC, c:1'b0, z:1'b0, e:1'b0, lat:2};
    t[3] = '{a:8'h81, b:8'h09, op:3'b101, u:1'b0, y:8'h02, c:1'b1, z:1'b0, e:1'b0, lat:2};
    t[4] = '{a:8'h81, b:8'h00, op:3'b101, u:1'b0, y:8'h81, c:1'b0, z:1'b0, e:1'b0, lat:2};
    t[5] = '{a:8'h40, b:8'h02, op:3'b101, u:1'b0, y:8'h00, c:1'b1, z:1'b1, e:1'b0, lat:2};
    for (int i = 0; i < 6; i++) begin
      run_op(t[i].a, t[i].b, t[i].op, t[i].u, lat, ry, rc, rz, re);
      total++;
      if ({ry, rc, rz, re} !== {t[i].y, t[i].c, t[i].z, t[i].e} || lat !== t[i].lat) begin
        bad++;
        $display("FAIL logic_shift[%0d] got y=%h c=%b z=%b e=%b lat=%0d want y=%h c=%b z=%b e=%b lat=%0d",
                 i, ry, rc, rz, re, lat, t[i].y, t[i].c, t[i].z, t[i].e, t[i].lat);
      end
    end
  endtask

  task automatic test_chain();
    vec_t t[6];
    int lat; logic [7:0] ry; logic rc, rz, re;
    t[0] = '{a:8'd10,  b:8'd20, op:3'b000, u:1'b0, y:8'd30, c:1'b0, z:1'b0, e:1'b0, lat:2};
    t[1] = '{a:8'hEE,  b:8'd1,  op:3'b000, u:1'b1, y:8'd31, c:1'b0, z:1'b0, e:1'b0, lat:2};
    t[2] = '{a:8'hEE,  b:8'd31, op:3'b001, u:1'b1, y:8'd0,  c:1'b0, z:1'b1, e:1'b0, lat:2};
    t[3] = '{a:8'd9,   b:8'd0,  op:3'b000, u:1'b0, y:8'd9,  c:1'b0, z:1'b0, e:1'b0, lat:2};
    t[4] = '{a:8'd77,  b:8'd66, op:3'b111, u:1'b0, y:8'd0,  c:1'b0, z:1'b1, e:1'b0, lat:2};
    t[5] = '{a:8'hEE,  b:8'd3,  op:3'b000, u:1'b1, y:8'd3,  c:1'b0, z:1'b0, e:1'b0, lat:2};
    for (int i = 0; i < 6; i++) begin
      run_op(t[i].a, t[i].b, t[i].op, t[i].u, lat, ry, rc, rz, re);
      total++;
      if ({ry, rc, rz, re} !== {t[i].y, t[i].c, t[i].z, t[i].e} || lat !== t[i].lat) begin
        bad++;
        $display("FAIL chain[%0d] got y=%h c=%b z=%b e=%b lat=%0d want y=%h c=%b z=%b e=%b lat=%0d",
                 i, ry, rc, rz, re, lat, t[i].y, t[i].c, t[i].z, t[i].e, t[i].lat);
      end
    end
  endtask

  task automatic test_mul();
    vec_t t[4];
    int lat; logic [7:0] ry; logic rc, rz, re;
`ifdef ACC_ALU_MUL_EN
    t[0] = '{a:8'd15, b:8'd17, op:3'b110, u:1'b0, y:8'd255, c:1'b0, z:1'b0, e:1'b0, lat:MUL_LAT};
    t[1] = '{a:8'd16, b:8'd16, op:3'b110, u:1'b0, y:8'd0,   c:1'b1, z:1'b1, e:1'b0, lat:MUL_LAT};
    t[2] = '{a:8'd3,  b:8'd5,  op:3'b110, u:1'b0, y:8'd15,  c:1'b0, z:1'b0, e:1'b0, lat:MUL_LAT};
    t[3] = '{a:8'hEE, b:8'd1,  op:3'b000, u:1'b1, y:8'd16,  c:1'b0, z:1'b0, e:1'b0, lat:2};
`else
    t[0] = '{a:8'd4,  b:8'd0,  op:3'b000, u:1'b0, y:8'd4,   c:1'b0, z:1'b0, e:1'b0, lat:2};
    t[1] = '{a:8'd15, b:8'd17, op:3'b110, u:1'b0, y:8'd0,   c:1'b0, z:1'b1, e:1'b1, lat:MUL_LAT};
    t[2] = '{a:8'd16, b:8'd16, op:3'b110, u:1'b1, y:8'd0,   c:1'b0, z:1'b1, e:1'b1, lat:MUL_LAT};
    t[3] = '{a:8'hEE, b:8'd0,  op:3'b000, u:1'b1, y:8'd4,   c:1'b0, z:1'b0, e:1'b0, lat:2};
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(t[i].a, t[i].b, t[i].op, t[i].u, lat, ry, rc, rz, re);
      total++;
      if ({ry, rc, rz, re} !== {t[i].y, t[i].c, t[i].z, t[i].e} || lat !== t[i].lat) begin
        bad++;
        $display("FAIL mul[%0d] got y=%h c=%b z=%b e=%b lat=%0d want y=%h c=%b z=%b e=%b lat=%0d",
                 i, ry, rc, rz, re, lat, t[i].y, t[i].c, t[i].z, t[i].e, t[i].lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    @(negedge clk);
    a = 8'd1; b = 8'd2; op = 3'b000; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL bp_latency got %0d want 2", lat);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 8'hAA; b = 8'h11; op = 3'b100; in_valid = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({out_valid, in_ready, y} !== {1'b1, 1'b0, 8'd3}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got ov=%b ir=%b y=%h want ov=1 ir=0 y=03",
                 i, out_valid, in_ready, y);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL bp_no_queue got %0d out_valid cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int lat; int seen; logic [7:0] ry; logic rc, rz, re;
    run_op(8'd5, 8'd6, 3'b000, 1'b0, lat, ry, rc, rz, re);
    total++;
    if ({ry, rc, rz, re} !== {8'd11, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rmid_preload got y=%h want 0b", ry);
    end
    @(negedge clk);
    a = 8'd3; b = 8'd3; op = 3'b110; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
`ifdef ACC_ALU_MUL_EN
    repeat (3) @(posedge clk);
`endif
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rmid_state got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rmid_no_result got %0d out_valid cycles want 0", seen);
    end
    run_op(8'hEE, 8'd0, 3'b000, 1'b1, lat, ry, rc, rz, re);
    total++;
    if ({ry, rc, rz, re} !== {8'd0, 1'b0, 1'b1, 1'b0} || lat !== 2) begin
      bad++;
      $display("FAIL rmid_acc got y=%h c=%b z=%b e=%b lat=%0d want y=00 c=0 z=1 e=0 lat=2",
               ry, rc, rz, re, lat);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic_shift();
    test_chain();
    test_mul();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
